// File: rtl/decode_pipe_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | decode_pipe_if                                                   |
// | Fetch-side and execute-side handshake bundle for decode_pipe.    |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
interface decode_pipe_if #(
  parameter int XLEN     = 32,
  parameter int ALU_OP_W = 5,
  parameter int CNT_W    = 16
);
  logic                flush;
  logic                in_valid;
  logic                in_ready;
  logic [31:0]         in_instr;
  logic [XLEN-1:0]     in_pc;
  logic                out_valid;
  logic                out_ready;
  logic [XLEN-1:0]     out_pc;
  logic [4:0]          out_rd;
  logic [4:0]          out_rs1;
  logic [4:0]          out_rs2;
  logic [ALU_OP_W-1:0] out_alu_op;
  logic [1:0]          out_alu_srca;
  logic [1:0]          out_alu_srcb;
  logic [1:0]          out_mem_wdsrc;
  logic                out_mem_we;
  logic [2:0]          out_dataout_src;
  logic                out_reg_we;
  logic                out_branch;
  logic                out_jalr;
  logic                out_jump;
  logic                out_illegal;
  logic [CNT_W-1:0]    illegal_cnt;

  // master: the surrounding pipeline (fetch + execute); slave: the decoder
  modport master (
    output flush, in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_rd, out_rs1, out_rs2, out_alu_op,
           out_alu_srca, out_alu_srcb, out_mem_wdsrc, out_mem_we, out_dataout_src,
           out_reg_we, out_branch, out_jalr, out_jump, out_illegal, illegal_cnt
  );

  modport slave (
    input  flush, in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_rd, out_rs1, out_rs2, out_alu_op,
           out_alu_srca, out_alu_srcb, out_mem_wdsrc, out_mem_we, out_dataout_src,
           out_reg_we, out_branch, out_jalr, out_jump, out_illegal, illegal_cnt
  );
endinterface
`default_nettype wire

// File: rtl/decode_pipe.sv
`default_nettype none
// +------------------------------------------------------------------+
// | decode_pipe                                                      |
// | Registered RV32I(+M) decoder with 2-entry skid buffer and flush. |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module decode_pipe #(
  parameter int XLEN     = 32,
  parameter int HAS_M    = 1,
  parameter int ALU_OP_W = 5,
  parameter int CNT_W    = 16
) (
  input logic          clk,
  input logic          reset,
  decode_pipe_if.slave io
);

  localparam int c_alu_add  = 0;
  localparam int c_alu_sub  = 1;
  localparam int c_alu_sll  = 2;
  localparam int c_alu_slt  = 3;
  localparam int c_alu_sltu = 4;
  localparam int c_alu_xor  = 5;
  localparam int c_alu_srl  = 6;
  localparam int c_alu_sra  = 7;
  localparam int c_alu_or   = 8;
  localparam int c_alu_and  = 9;
  localparam int c_alu_beq  = 10;
  localparam int c_alu_bne  = 11;
  localparam int c_alu_blt  = 12;
  localparam int c_alu_bge  = 13;
  localparam int c_alu_bltu = 14;
  localparam int c_alu_bgeu = 15;
  localparam int c_alu_mul  = 16;

  localparam logic [1:0] c_srca_rs1  = 2'd0;
  localparam logic [1:0] c_srca_pc   = 2'd1;
  localparam logic [1:0] c_srca_zero = 2'd2;
  localparam logic [1:0] c_srcb_rs2  = 2'd0;
  localparam logic [1:0] c_srcb_imm  = 2'd1;

  localparam logic [2:0] c_wb_alu = 3'd0;
  localparam logic [2:0] c_wb_lb  = 3'd1;
  localparam logic [2:0] c_wb_lh  = 3'd2;
  localparam logic [2:0] c_wb_lw  = 3'd3;
  localparam logic [2:0] c_wb_lbu = 3'd4;
  localparam logic [2:0] c_wb_lhu = 3'd5;
  localparam logic [2:0] c_wb_pc4 = 3'd6;

  localparam logic [4:0] c_opc_load   = 5'b00000;
  localparam logic [4:0] c_opc_op_imm = 5'b00100;
  localparam logic [4:0] c_opc_auipc  = 5'b00101;
  localparam logic [4:0] c_opc_store  = 5'b01000;
  localparam logic [4:0] c_opc_op     = 5'b01100;
  localparam logic [4:0] c_opc_lui    = 5'b01101;
  localparam logic [4:0] c_opc_branch = 5'b11000;
  localparam logic [4:0] c_opc_jalr   = 5'b11001;
  localparam logic [4:0] c_opc_jal    = 5'b11011;

  typedef struct packed {
    logic [XLEN-1:0]     pc;
    logic [4:0]          rd;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic [ALU_OP_W-1:0] alu_op;
    logic [1:0]          alu_srca;
    logic [1:0]          alu_srcb;
    logic [1:0]          mem_wdsrc;
    logic                mem_we;
    logic [2:0]          dataout_src;
    logic                reg_we;
    logic                branch;
    logic                jalr;
    logic                jump;
    logic                illegal;
  } bundle_t;

  function automatic logic [ALU_OP_W-1:0] alu_base(input logic [2:0] f3);
    int op;
    case (f3)
      3'b000:  op = c_alu_add;
      3'b001:  op = c_alu_sll;
      3'b010:  op = c_alu_slt;
      3'b011:  op = c_alu_sltu;
      3'b100:  op = c_alu_xor;
      3'b101:  op = c_alu_srl;
      3'b110:  op = c_alu_or;
      default: op = c_alu_and;
    endcase
    return ALU_OP_W'(op);
  endfunction

  logic [2:0] f3;
  logic [6:0] f7;
  assign f3 = io.in_instr[14:12];
  assign f7 = io.in_instr[31:25];

  bundle_t dec;
  logic    legal;

  always_comb begin
    dec     = '0;
    legal   = 1'b0;
    dec.pc  = io.in_pc;
    dec.rd  = io.in_instr[11:7];
    dec.rs1 = io.in_instr[19:15];
    dec.rs2 = io.in_instr[24:20];
    if (io.in_instr[1:0] == 2'b11) begin
      case (io.in_instr[6:2])
        c_opc_lui: begin
          legal = 1'b1; dec.alu_srca = c_srca_zero; dec.alu_srcb = c_srcb_imm; dec.reg_we = 1'b1;
        end
        c_opc_auipc: begin
          legal = 1'b1; dec.alu_srca = c_srca_pc; dec.alu_srcb = c_srcb_imm; dec.reg_we = 1'b1;
        end
        c_opc_jal: begin
          legal = 1'b1; dec.alu_srca = c_srca_pc; dec.alu_srcb = c_srcb_imm;
          dec.jump = 1'b1; dec.reg_we = 1'b1; dec.dataout_src = c_wb_pc4;
        end
        c_opc_jalr: begin
          legal = (f3 == 3'b000); dec.alu_srca = c_srca_rs1; dec.alu_srcb = c_srcb_imm;
          dec.jalr = 1'b1; dec.reg_we = 1'b1; dec.dataout_src = c_wb_pc4;
        end
        c_opc_branch: begin
          dec.branch = 1'b1; dec.alu_srca = c_srca_rs1; dec.alu_srcb = c_srcb_rs2;
          case (f3)
            3'b000:  begin legal = 1'b1; dec.alu_op = ALU_OP_W'(c_alu_beq);  end
            3'b001:  begin legal = 1'b1; dec.alu_op = ALU_OP_W'(c_alu_bne);  end
            3'b100:  begin legal = 1'b1; dec.alu_op = ALU_OP_W'(c_alu_blt);  end
            3'b101:  begin legal = 1'b1; dec.alu_op = ALU_OP_W'(c_alu_bge);  end
            3'b110:  begin legal = 1'b1; dec.alu_op = ALU_OP_W'(c_alu_bltu); end
            3'b111:  begin legal = 1'b1; dec.alu_op = ALU_OP_W'(c_alu_bgeu); end
            default: legal = 1'b0;
          endcase
        end
        c_opc_load: begin
          dec.alu_srcb = c_srcb_imm; dec.reg_we = 1'b1;
          case (f3)
            3'b000:  begin legal = 1'b1; dec.dataout_src = c_wb_lb;  end
            3'b001:  begin legal = 1'b1; dec.dataout_src = c_wb_lh;  end
            3'b010:  begin legal = 1'b1; dec.dataout_src = c_wb_lw;  end
            3'b100:  begin legal = 1'b1; dec.dataout_src = c_wb_lbu; end
            3'b101:  begin legal = 1'b1; dec.dataout_src = c_wb_lhu; end
            default: legal = 1'b0;
          endcase
        end
        c_opc_store: begin
          legal = !f3[2] && (f3[1:0] != 2'b11);
          dec.alu_srcb = c_srcb_imm; dec.mem_we = 1'b1; dec.mem_wdsrc = f3[1:0];
        end
        c_opc_op_imm: begin
          dec.alu_srcb = c_srcb_imm; dec.reg_we = 1'b1; dec.dataout_src = c_wb_alu;
          case (f3)
            3'b001: begin
              legal = (f7 == 7'b0000000); dec.alu_op = ALU_OP_W'(c_alu_sll);
            end
            3'b101: begin
              legal = (f7 == 7'b0000000) || (f7 == 7'b0100000);
              dec.alu_op = f7[5] ? ALU_OP_W'(c_alu_sra) : ALU_OP_W'(c_alu_srl);
            end
            default: begin legal = 1'b1; dec.alu_op = alu_base(f3); end
          endcase
        end
        c_opc_op: begin
          dec.alu_srcb = c_srcb_rs2; dec.reg_we = 1'b1;
          case (f7)
            7'b0000000: begin legal = 1'b1; dec.alu_op = alu_base(f3); end
            7'b0100000: begin
              legal = (f3 == 3'b000) || (f3 == 3'b101);
              dec.alu_op = (f3 == 3'b000) ? ALU_OP_W'(c_alu_sub) : ALU_OP_W'(c_alu_sra);
            end
            7'b0000001: begin
              legal = (HAS_M != 0); dec.alu_op = ALU_OP_W'(c_alu_mul + int'(f3));
            end
            default: legal = 1'b0;
          endcase
        end
        default: legal = 1'b0;
      endcase
    end
    // Illegal bundles keep only pc and register indices so execute sees no side effects
    if (!legal) begin
      dec.alu_op      = '0;
      dec.alu_srca    = '0;
      dec.alu_srcb    = '0;
      dec.mem_wdsrc   = '0;
      dec.mem_we      = 1'b0;
      dec.dataout_src = '0;
      dec.reg_we      = 1'b0;
      dec.branch      = 1'b0;
      dec.jalr        = 1'b0;
      dec.jump        = 1'b0;
      dec.illegal     = 1'b1;
    end
  end

  bundle_t          or_q, or_d, sr_q, sr_d;
  logic             or_valid_q, or_valid_d, sr_valid_q, sr_valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             in_ready, accept, fire;

  assign in_ready = !sr_valid_q && !reset;
  assign accept   = io.in_valid && in_ready;
  assign fire     = or_valid_q && io.out_ready;

  always_comb begin
    or_valid_d = or_valid_q;
    or_d       = or_q;
    sr_valid_d = sr_valid_q;
    sr_d       = sr_q;
    cnt_d      = cnt_q;
    if (io.flush) begin
      or_valid_d = 1'b0;
      or_d       = '0;
      sr_valid_d = 1'b0;
      sr_d       = '0;
    end else begin
      if (!or_valid_q || fire) begin
        // SR always holds the older instruction, so it drains before new input
        if (sr_valid_q) begin
          or_valid_d = 1'b1;
          or_d       = sr_q;
          sr_valid_d = 1'b0;
        end else if (accept) begin
          or_valid_d = 1'b1;
          or_d       = dec;
        end else begin
          or_valid_d = 1'b0;
        end
      end else if (accept) begin
        sr_valid_d = 1'b1;
        sr_d       = dec;
      end
      if (accept && dec.illegal && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      or_valid_q <= 1'b0;
      or_q       <= '0;
      sr_valid_q <= 1'b0;
      sr_q       <= '0;
      cnt_q      <= '0;
    end else begin
      or_valid_q <= or_valid_d;
      or_q       <= or_d;
      sr_valid_q <= sr_valid_d;
      sr_q       <= sr_d;
      cnt_q      <= cnt_d;
    end
  end

  assign io.in_ready        = in_ready;
  assign io.out_valid       = or_valid_q;
  assign io.out_pc          = or_q.pc;
  assign io.out_rd          = or_q.rd;
  assign io.out_rs1         = or_q.rs1;
  assign io.out_rs2         = or_q.rs2;
  assign io.out_alu_op      = or_q.alu_op;
  assign io.out_alu_srca    = or_q.alu_srca;
  assign io.out_alu_srcb    = or_q.alu_srcb;
  assign io.out_mem_wdsrc   = or_q.mem_wdsrc;
  assign io.out_mem_we      = or_q.mem_we;
  assign io.out_dataout_src = or_q.dataout_src;
  assign io.out_reg_we      = or_q.reg_we;
  assign io.out_branch      = or_q.branch;
  assign io.out_jalr        = or_q.jalr;
  assign io.out_jump        = or_q.jump;
  assign io.out_illegal     = or_q.illegal;
  assign io.illegal_cnt     = cnt_q;

endmodule
`default_nettype wire

// File: doc/decode_pipe.md
Name: decode_pipe

Overview:
- Registered, parametrised successor to the combinational RV32I controller; sits between the fetch and execute stages.
- Decodes a 32-bit instruction into the execute control bundle and register indices, and passes the PC through.
- Adds a valid/ready handshake with a 2-entry skid buffer, synchronous flush, and optional M-extension decode.
- Adds strict illegal-instruction detection with deterministic (non-X) don't-care outputs, plus a saturating illegal-instruction counter.

Parameters:
- XLEN, 32, width of pc passthrough
- HAS_M, 1, 1 = decode MUL/DIV/REM (funct7=0000001, OP=0110011); 0 = these encodings are illegal
- ALU_OP_W, 5, alu_op width; existing EXE_*_OP codes keep their values; M ops are 16..23 in funct3 order (MUL=16 ... REMU=23)
- CNT_W, 16, illegal counter width

Ports:
- clk  in  1  clock
- reset  in  1  reset
- flush  in  1  discard all held and incoming instructions
- in_valid  in  1  instruction presented
- in_ready  out  1  decode can accept
- in_instr  in  32  instruction word
- in_pc  in  XLEN  instruction PC
- out_valid  out  1  decoded bundle valid
- out_ready  in  1  execute accepts bundle
- out_pc  out  XLEN  registered PC
- out_rd, out_rs1, out_rs2  out  5 each  register fields
- out_alu_op  out  ALU_OP_W  ALU operation
- out_alu_srca, out_alu_srcb  out  2 each  ALU operand selects
- out_mem_wdsrc  out  2  store width
- out_mem_we  out  1  store enable
- out_dataout_src  out  3  writeback source
- out_reg_we, out_branch, out_jalr, out_jump  out  1 each  control flags
- out_illegal  out  1  instruction illegal
- illegal_cnt  out  CNT_W  saturating count of illegal instructions accepted

Behaviour:
- All state is reset synchronously on reset=1 (active-high); out_valid=0, skid empty, in_ready=0 during the reset cycle and 1 the cycle after, all out_* fields=0, illegal_cnt=0.
- Decode is combinational on in_instr and is registered on acceptance (in_valid && in_ready). Latency is 1 cycle: a bundle accepted at edge N is visible with out_valid=1 after edge N.
- Output register (OR) and skid register (SR):
  - in_ready = !SR_full.
  - Output handshake completes when out_valid && out_ready.
  - If OR is empty, or OR completes this cycle: OR loads from SR when SR is full (SR empties), else from the input when accepted.
  - If OR is held (out_valid && !out_ready) and an input is accepted, the input goes to SR.
  - Order is preserved; no bubble while out_ready=1; full throughput of 1 instruction per cycle.
- out_* must stay stable while out_valid && !out_ready.
- flush=1: at the next edge OR and SR are cleared (out_valid=0) and any input accepted in that cycle is dropped and not counted. in_ready=1 the following cycle. flush has priority over all handshakes; reset has priority over flush.
- Legal set: LUI, AUIPC, JAL, JALR (funct3=000), BRANCH (funct3 in {000,001,100,101,110,111}), LOAD (funct3 in {000,001,010,100,101}), STORE (funct3 in {000,001,010}), OP_IMM, OP.
  - SLLI requires funct7=0000000; SRLI/SRAI require funct7 in {0000000,0100000}.
  - OP: funct7=0000000 for all funct3; funct7=0100000 only for funct3 000 (SUB) and 101 (SRA); funct7=0000001 only when HAS_M=1.
  - Bits [1:0] != 11 → illegal.
  - Everything else is illegal.
- Field values per opcode are identical to the existing controller. LOAD and STORE use alu_op=ADD. Every don't-care field is driven to 0, never X.
- Illegal bundle: out_illegal=1, reg_we=mem_we=branch=jalr=jump=0, all other fields 0 except rd/rs1/rs2/pc, which pass through.
- illegal_cnt increments by 1 when an illegal instruction is accepted (not flushed) and saturates at all-ones.

Test Plan:
- After reset, drive 0x00500093 (ADDI x1,x0,5) at pc 0x100 with out_ready=1 → next cycle out_valid=1, rd=1, rs1=0, alu_op=ADD, srcb=IMM, reg_we=1, illegal=0, out_pc=0x100.
- Stream 0x40208133 (SUB), 0x022081B3 (MUL), 0x402091B3 back-to-back → SUB bundle; MUL with alu_op=16 (HAS_M=1) or illegal=1 (HAS_M=0); third bundle illegal=1 with reg_we=0; illegal_cnt increments on each illegal acceptance.
- out_ready=0 for 3 cycles while 3 instructions are offered → first two are held (OR+SR), in_ready=0 on the third. Raise out_ready → bundles emerge in order 1,2,3 on consecutive cycles with no loss or duplication.
- With OR and SR full, assert flush together with in_valid → next cycle out_valid=0 and in_ready=1; the flushed instructions never appear and illegal_cnt is unchanged.
- Drive 0x00000000 repeatedly with CNT_W=4 → illegal_cnt saturates at 15; out_branch=out_jump=out_mem_we=0 throughout.
- Assert reset mid-stream with OR and SR full → following cycle out_valid=0, illegal_cnt=0, all out_* fields=0.
